// File: rtl/clk_divider_multi.sv
// Multi-channel programmable clock divider: each channel produces a 50%-duty square
// wave with a runtime half-period, a rising-edge tick, and glitch-free divisor updates.
module clk_divider_multi #(
   parameter int N_CH        = 2,
   parameter int CNT_W       = 28,
   parameter int CH_W        = 1,
   parameter int DEFAULT_DIV = 50000000
) (
   input  logic             master_clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sync_restart,
   input  logic             wr_en,
   input  logic [CH_W-1:0]  wr_ch,
   input  logic [CNT_W-1:0] wr_div,
   output logic [N_CH-1:0]  clk_out,
   output logic [N_CH-1:0]  tick,
   output logic [N_CH-1:0]  pend
);

   localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   genvar i;
   generate
      for (i = 0; i < N_CH; i++) begin : g_ch
         logic [CNT_W-1:0] cnt;
         logic [CNT_W-1:0] div_act;
         logic [CNT_W-1:0] div_sh;
         logic [CNT_W-1:0] next_div;
         logic             wr_hit;
         logic             idle;
         logic             tc;
         logic             clk_r;
         logic             tick_r;
         logic             pend_r;

         // Out-of-range channel indices never match any channel, so they are dropped.
         assign wr_hit   = wr_en && (int'(wr_ch) == i);
         assign idle     = (div_act == '0);
         assign tc       = !idle && (cnt == div_act - ONE);
         // A write landing on the same cycle as an apply point wins over the shadow.
         assign next_div = wr_hit ? wr_div : div_sh;

         always_ff @(posedge master_clk or negedge rst) begin
            if (!rst) begin
               cnt     <= '0;
               div_act <= DEF_DIV;
               div_sh  <= DEF_DIV;
               clk_r   <= 1'b0;
               tick_r  <= 1'b0;
               pend_r  <= 1'b0;
            end else if (sync_restart) begin
               cnt     <= '0;
               div_act <= next_div;
               div_sh  <= next_div;
               clk_r   <= 1'b0;
               tick_r  <= 1'b0;
               pend_r  <= 1'b0;
            end else if (idle) begin
               cnt    <= '0;
               clk_r  <= 1'b0;
               tick_r <= 1'b0;
               if (wr_hit) begin
                  div_act <= wr_div;
                  div_sh  <= wr_div;
                  pend_r  <= 1'b0;
               end
            end else if (en && tc) begin
               cnt     <= '0;
               div_act <= next_div;
               div_sh  <= next_div;
               pend_r  <= 1'b0;
               if (next_div == '0) begin
                  clk_r  <= 1'b0;
                  tick_r <= 1'b0;
               end else begin
                  clk_r  <= ~clk_r;
                  tick_r <= ~clk_r;
               end
            end else begin
               if (en) begin
                  cnt <= cnt + ONE;
               end
               tick_r <= 1'b0;
               if (wr_hit) begin
                  div_sh <= wr_div;
                  pend_r <= 1'b1;
               end
            end
         end

         assign clk_out[i] = clk_r;
         assign tick[i]    = tick_r;
         assign pend[i]    = pend_r;
      end
   endgenerate

endmodule
